mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester memory arbiter that shares one downstream memory port between the core's instruction bus and data bus. It sits between the core and the memory/cache side. It serialises fetch and load/store transactions through a four-state FSM and routes the single response back to the requester that owns it. Data requests have priority, and a streak counter bounds instruction-fetch starvation.

## Interface
- `STARVE_LIMIT`, default 4: number of consecutive data grants won while a fetch was pending, after which the fetch wins the next contested arbitration.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `ireq_valid` in 1: fetch request. Held by the requester until `iresp_data_ok`.
- `ireq_addr` in 64: fetch byte address, 4-byte aligned.
- `iresp_data_ok` out 1: one-cycle pulse; fetch complete.
- `iresp_data` out 32: instruction word.
- `dreq_valid` in 1: data request. Held by the requester until `dresp_data_ok`.
- `dreq_addr` in 64, `dreq_size` in 3, `dreq_strobe` in 8, `dreq_data` in 64: data request fields. A request is a write when `dreq_strobe != 0`.
- `dresp_data_ok` out 1: one-cycle pulse; data access complete.
- `dresp_data` out 64: load data, raw aligned 64-bit word.
- `m_req_valid` out 1, `m_req_ready` in 1: downstream request handshake.
- `m_req_addr` out 64, `m_req_size` out 3, `m_req_strobe` out 8, `m_req_data` out 64, `m_req_write` out 1: downstream request fields.
- `m_resp_valid` in 1, `m_resp_data` in 64: downstream response, an aligned 64-bit word.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - If no request is valid, stay in IDLE.
  - Otherwise latch the winner's fields and owner (I or D), then go to REQ.
- **Arbitration (IDLE only)**
  - Only D valid → D wins. Only I valid → I wins.
  - Both valid → D wins, unless `streak == STARVE_LIMIT`, in which case I wins.
- **Streak counter**
  - Width is $clog2(STARVE_LIMIT+1).
  - Increments when D wins while `ireq_valid` is 1, saturating at `STARVE_LIMIT`.
  - Clears whenever I wins.
  - Unchanged when D wins uncontested.
- **REQ**
  - `m_req_valid` is 1 and all `m_req_*` outputs are driven from the latched registers, stable until the handshake.
  - On `m_req_ready` go to WAIT.
- **WAIT**
  - On `m_resp_valid`, capture `m_resp_data` and go to RESP.
  - `m_resp_valid` is ignored in every state other than WAIT.
- **RESP**
  - Pulse the owner's `*_data_ok` for exactly one cycle, then go to IDLE.
  - `iresp_data` = captured word [63:32] if latched addr[2] is 1, else [31:0].
  - `dresp_data` = the full captured word.
- **Fetch requests downstream**: `m_req_size` = 3'd2, `m_req_strobe` = 0, `m_req_write` = 0, `m_req_data` = 0.
- **Requester drops valid mid-transaction** (for example a flush): the transaction still completes and `data_ok` still pulses. The requester discards it.
- **Wide-open RESP rule**: arbitration never occurs in RESP. This keeps a requester from being re-granted its just-completed request before it has advanced its address.

## Timing
- Reset values: state IDLE, streak 0. Every output is 0, including `iresp_data`, `dresp_data` and all `m_req_*` fields.
- A reset in any state aborts the transaction; the downstream side shares the same reset.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- Minimum latency, with the request seen in IDLE at cycle T:
  - `m_req_valid` at T+1.
  - If `m_req_ready` at T+1, the FSM is in WAIT at T+2.
  - If `m_resp_valid` at T+2, `data_ok` pulses at T+3.
  - The FSM is back in IDLE at T+4.
- Back-to-back transactions have a throughput of one per 4 cycles minimum.
- `m_req_ready` stalls extend REQ indefinitely, with fields held. Response stalls extend WAIT indefinitely.
- The `data_ok` pulses are mutually exclusive and never more than one cycle long.

## Structure
- A shared package `arb_pkg` holds:
  - the `arb_state_t` enum (IDLE/REQ/WAIT/RESP);
  - the `arb_owner_t` enum (OWN_I/OWN_D);
  - a packed `mem_req_t` struct (addr, size, strobe, data, write) used for the latched request;
  - the constant `FETCH_SIZE = 3'd2`.
- Sub-module `arb_priority`: purely combinational winner selection from (`ireq_valid`, `dreq_valid`, `streak`). The FSM, streak counter and datapath registers live in `mem_arbiter`.

## Test plan
- **Single fetch**: `ireq_valid`=1, addr 0x8000_0004, memory returns 0x1111_2222_3333_4444 with ready and resp at 0 wait.
  - `m_req_valid` at T+1 with size 2, write 0.
  - `iresp_data_ok` at T+3 with data 0x1111_2222.
- **Store**: `dreq_valid`, addr 0x8010_0008, strobe 0x0F, data 0xDEAD_BEEF.
  - `m_req_write`=1 and fields match.
  - `dresp_data_ok` pulses once.
  - `iresp_data_ok` stays 0.
- **Contention**: both valid continuously with `STARVE_LIMIT`=4.
  - Grant order is D,D,D,D,I,D,D,D,D,I.
  - Streak reads 0 after each I grant.
- **Stalls**: hold `m_req_ready`=0 for 5 cycles, then `m_resp_valid`=0 for 3 cycles.
  - `m_req_*` stable throughout.
  - Exactly one `data_ok`, arriving 1 cycle after `m_resp_valid`.
  - A spurious `m_resp_valid` in IDLE is ignored.
- **Dropped request**: deassert `dreq_valid` while in WAIT.
  - `dresp_data_ok` still pulses.
  - The next grant goes to a pending fetch.
- **Reset mid-operation**: assert reset in WAIT.
  - Next cycle all outputs are 0, state is IDLE, streak is 0.
  - A fresh fetch completes normally afterward.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_I, OWN_D} arb_owner_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic        write;
  } mem_req_t;

  localparam logic [2:0] FETCH_SIZE = 3'd2;
endpackage

// File: rtl/arb_priority.sv
// Combinational winner selection: data first unless fetch has starved STARVE_LIMIT times.
module arb_priority #(
  parameter int STARVE_LIMIT = 4,
  parameter int SW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          ireq_valid,
  input  logic          dreq_valid,
  input  logic [SW-1:0] streak,
  output logic          grant,
  output logic          win_d
);
  always_comb begin
    grant = ireq_valid | dreq_valid;
    win_d = dreq_valid & ~(ireq_valid & (streak == SW'(STARVE_LIMIT)));
  end
endmodule

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store requests onto one memory port and routes
// the response back to its owner.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [63:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [7:0]  dreq_strobe,
  input  logic [63:0] dreq_data,
  output logic        dresp_data_ok,
  output logic [63:0] dresp_data,
  output logic        m_req_valid,
  input  logic        m_req_ready,
  output logic [63:0] m_req_addr,
  output logic [2:0]  m_req_size,
  output logic [7:0]  m_req_strobe,
  output logic [63:0] m_req_data,
  output logic        m_req_write,
  input  logic        m_resp_valid,
  input  logic [63:0] m_resp_data
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_t    state, state_nx;
  arb_owner_t    owner;
  mem_req_t      req;
  logic [63:0]   resp_word;
  logic [SW-1:0] streak;
  logic          grant, win_d;

  arb_priority #(.STARVE_LIMIT(STARVE_LIMIT), .SW(SW)) u_prio (
    .ireq_valid (ireq_valid),
    .dreq_valid (dreq_valid),
    .streak     (streak),
    .grant      (grant),
    .win_d      (win_d)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Arbitration happens only in IDLE, so RESP never re-grants a stale request.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant)        state_nx = REQ;
      REQ:     if (m_req_ready)  state_nx = WAIT;
      WAIT:    if (m_resp_valid) state_nx = RESP;
      RESP:                      state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_I;
      req       <= '0;
      resp_word <= '0;
      streak    <= '0;
    end else begin
      if (state == IDLE && grant) begin
        if (win_d) begin
          owner <= OWN_D;
          req   <= '{addr: dreq_addr, size: dreq_size, strobe: dreq_strobe,
                     data: dreq_data, write: |dreq_strobe};
          // Only contested data wins count toward fetch starvation.
          if (ireq_valid && streak != SW'(STARVE_LIMIT)) streak <= streak + SW'(1);
        end else begin
          owner  <= OWN_I;
          req    <= '{addr: ireq_addr, size: FETCH_SIZE, strobe: 8'h00,
                      data: 64'h0, write: 1'b0};
          streak <= '0;
        end
      end
      if (state == WAIT && m_resp_valid) resp_word <= m_resp_data;
    end
  end

  always_comb begin
    m_req_valid   = (state == REQ);
    iresp_data_ok = (state == RESP) && (owner == OWN_I);
    dresp_data_ok = (state == RESP) && (owner == OWN_D);
  end

  assign m_req_addr   = req.addr;
  assign m_req_size   = req.size;
  assign m_req_strobe = req.strobe;
  assign m_req_data   = req.data;
  assign m_req_write  = req.write;
  assign iresp_data   = req.addr[2] ? resp_word[63:32] : resp_word[31:0];
  assign dresp_data   = resp_word;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: requester/memory models plus directed and random phases.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import arb_pkg::*;
  localparam int LIMIT = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        ireq_valid = 1'b0;
  logic [63:0] ireq_addr = '0;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid = 1'b0;
  logic [63:0] dreq_addr = '0;
  logic [2:0]  dreq_size = '0;
  logic [7:0]  dreq_strobe = '0;
  logic [63:0] dreq_data = '0;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        m_req_valid, m_req_ready = 1'b0;
  logic [63:0] m_req_addr, m_req_data;
  logic [2:0]  m_req_size;
  logic [7:0]  m_req_strobe;
  logic        m_req_write;
  logic        m_resp_valid = 1'b0;
  logic [63:0] m_resp_data = '0;
  logic [139:0] mreq_f;

  always #5 clk = ~clk;
  assign mreq_f = {m_req_addr, m_req_size, m_req_strobe, m_req_data, m_req_write};

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_addr(m_req_addr), .m_req_size(m_req_size), .m_req_strobe(m_req_strobe),
    .m_req_data(m_req_data), .m_req_write(m_req_write),
    .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data)
  );

  typedef struct { logic [63:0] addr; logic [2:0] size; logic [7:0] strobe; logic [63:0] data; bit drop; } dtxn_t;
  typedef struct { bit own_d; logic [63:0] data; } exp_t;

  logic [63:0] iq[$];
  dtxn_t       dq[$];
  exp_t        sbq[$];
  bit          glog[$];   // grant order, 1 = data

  int errors = 0, checks = 0, cyc = 0;
  bit i_busy, d_busy, prev_iv, prev_dv, prev_mv, prev_iok, prev_dok;
  logic [63:0] prev_ia, g_addr, out_addr;
  dtxn_t dcur, prev_d;
  int cnt;
  bit pred_d, req_seen, outstanding, out_own_d;
  int rstall, wstall;
  logic [139:0] held;
  bit rand_mode, spurious;
  int fix_rdy, fix_resp;
  int n_iok, n_dok, i_raise_cyc, grant_cyc, iok_cyc, dok_cyc, resp_cyc;
  logic [2:0] g_size;
  logic g_write;
  logic [31:0] last_idata;

  task automatic check(string name, logic [139:0] act, logic [139:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(string name, string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Memory contents: a deterministic hash of the aligned address.
  function automatic logic [63:0] mem_word(logic [63:0] a);
    logic [63:0] x;
    x = {a[63:3], 3'b000} - 64'h8000_0000;
    return 64'h1111_2222_3333_4444 ^ (x * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  function automatic logic [63:0] fetch_exp(logic [63:0] a);
    logic [63:0] w;
    w = mem_word(a);
    return a[2] ? {32'h0, w[63:32]} : {32'h0, w[31:0]};
  endfunction

  // All models live on the falling edge: sample DUT, then drive next inputs.
  initial begin
    exp_t e;
    logic [139:0] exp_f;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        ireq_valid = 0; dreq_valid = 0; m_req_ready = 0; m_resp_valid = 0;
        i_busy = 0; d_busy = 0; sbq.delete(); cnt = 0; req_seen = 0; outstanding = 0;
        prev_iv = 0; prev_dv = 0; prev_mv = 0; prev_iok = 0; prev_dok = 0;
        continue;
      end

      // response monitor
      if (iresp_data_ok || dresp_data_ok) begin
        check("ok_exclusive", iresp_data_ok & dresp_data_ok, 0);
        check("ok_one_cycle", (iresp_data_ok & prev_iok) | (dresp_data_ok & prev_dok), 0);
        if (iresp_data_ok) begin n_iok++; iok_cyc = cyc; last_idata = iresp_data; end
        if (dresp_data_ok) begin n_dok++; dok_cyc = cyc; end
        if (sbq.size() == 0) fail("unexpected_resp", "data_ok with no transaction outstanding");
        else begin
          e = sbq.pop_front();
          check("resp_owner", dresp_data_ok, e.own_d);
          check("resp_data", dresp_data_ok ? dresp_data : {32'h0, iresp_data}, e.data);
        end
      end

      // grant predictor: a grant is the rise of m_req_valid
      if (m_req_valid && !prev_mv) begin
        grant_cyc = cyc; g_size = m_req_size; g_write = m_req_write;
        if (!prev_iv && !prev_dv) fail("grant_no_req", "grant with no requester valid");
        else begin
          if (prev_dv && !(prev_iv && cnt == LIMIT)) begin
            pred_d = 1;
            if (prev_iv && cnt < LIMIT) cnt++;
          end else begin
            pred_d = 0;
            cnt = 0;
          end
          glog.push_back(pred_d);
          if (pred_d) exp_f = {prev_d.addr, prev_d.size, prev_d.strobe, prev_d.data, prev_d.strobe != 8'h0};
          else        exp_f = {prev_ia, 3'd2, 8'h00, 64'h0, 1'b0};
          check("grant_fields", mreq_f, exp_f);
          check("streak", dut.streak, cnt);
          g_addr = pred_d ? prev_d.addr : prev_ia;
        end
      end

      // memory model
      m_req_ready = 0; m_resp_valid = 0;
      if (outstanding) begin
        if (wstall > 0) wstall--;
        else begin
          m_resp_valid = 1; m_resp_data = mem_word(out_addr); outstanding = 0; resp_cyc = cyc;
        end
      end else if (m_req_valid) begin
        if (!req_seen) begin
          req_seen = 1; held = mreq_f;
          rstall = rand_mode ? $urandom_range(0, 3) : fix_rdy;
        end else check("req_stable", mreq_f, held);
        if (rstall > 0) rstall--;
        else begin
          m_req_ready = 1; req_seen = 0; outstanding = 1; out_own_d = pred_d; out_addr = g_addr;
          wstall = rand_mode ? $urandom_range(0, 3) : fix_resp;
          e.own_d = pred_d;
          e.data  = pred_d ? mem_word(g_addr) : fetch_exp(g_addr);
          sbq.push_back(e);
        end
      end else if (spurious && $urandom_range(0, 2) == 0) begin
        m_resp_valid = 1; m_resp_data = {$urandom, $urandom};
      end

      // requesters: hold valid until data_ok, reissue on the completion edge
      if (iresp_data_ok) begin i_busy = 0; ireq_valid = 0; end
      if (!i_busy && iq.size() > 0 && (!rand_mode || $urandom_range(0, 1) == 0)) begin
        ireq_addr = iq.pop_front(); ireq_valid = 1; i_busy = 1; i_raise_cyc = cyc;
      end
      if (dresp_data_ok) begin d_busy = 0; dreq_valid = 0; end
      if (d_busy && dcur.drop && outstanding && out_own_d) dreq_valid = 0;
      if (!d_busy && dq.size() > 0 && (!rand_mode || $urandom_range(0, 1) == 0)) begin
        dcur = dq.pop_front();
        dreq_addr = dcur.addr; dreq_size = dcur.size; dreq_strobe = dcur.strobe; dreq_data = dcur.data;
        dreq_valid = 1; d_busy = 1;
      end
      prev_iv = ireq_valid; prev_dv = dreq_valid; prev_ia = ireq_addr; prev_d = dcur;
      prev_mv = m_req_valid; prev_iok = iresp_data_ok; prev_dok = dresp_data_ok;
    end
  end

  task automatic do_reset(bit chk);
    @(posedge clk); #1 reset = 1;
    @(posedge clk);
    @(negedge clk); #1;
    if (chk) begin
      check("rst_m_req_valid", m_req_valid, 0);
      check("rst_m_req_fields", mreq_f, 0);
      check("rst_data_ok", {iresp_data_ok, dresp_data_ok}, 0);
      check("rst_resp_data", {iresp_data, dresp_data}, 0);
      check("rst_state_idle", dut.state == IDLE, 1);
      check("rst_streak", dut.streak, 0);
    end
    glog.delete(); n_iok = 0; n_dok = 0;
    @(posedge clk); #1 reset = 0;
  endtask

  task automatic wait_done(string name, int budget);
    int n = 0;
    while ((iq.size() > 0 || dq.size() > 0 || i_busy || d_busy || sbq.size() > 0 || outstanding) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, required all transactions complete", name, n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic dtxn_t rand_d(bit drop);
    dtxn_t t;
    t.addr   = 64'h8000_0000 + 64'($urandom_range(0, 4095));
    t.size   = 3'($urandom_range(0, 3));
    t.strobe = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
    t.data   = {$urandom, $urandom};
    t.drop   = drop;
    return t;
  endfunction

  initial begin
    dtxn_t t;
    int n;
    rand_mode = 0; spurious = 0; fix_rdy = 0; fix_resp = 0;
    do_reset(1);

    // single zero-wait fetch
    iq.push_back(64'h8000_0004);
    wait_done("single_fetch", 50);
    check("fetch_grant_latency", grant_cyc - i_raise_cyc, 1);
    check("fetch_ok_latency", iok_cyc - i_raise_cyc, 3);
    check("fetch_data", last_idata, 32'h1111_2222);
    check("fetch_size", g_size, 2);
    check("fetch_write", g_write, 0);
    check("fetch_count", n_iok, 1);

    // store
    n_iok = 0; n_dok = 0;
    t = '{addr: 64'h8010_0008, size: 3'd3, strobe: 8'h0F, data: 64'hDEAD_BEEF, drop: 0};
    dq.push_back(t);
    wait_done("store", 50);
    check("store_write", g_write, 1);
    check("store_dok_count", n_dok, 1);
    check("store_iok_count", n_iok, 0);

    // ready and response stalls, then spurious responses while idle
    n_iok = 0; n_dok = 0; fix_rdy = 5; fix_resp = 3; spurious = 1;
    iq.push_back(64'h8000_0100);
    wait_done("stalls", 80);
    check("stall_ok_after_resp", iok_cyc - resp_cyc, 1);
    check("stall_latency", iok_cyc - grant_cyc, 10);
    repeat (12) @(posedge clk);
    #1;
    check("spurious_ignored", n_iok + n_dok, 1);
    spurious = 0; fix_rdy = 0; fix_resp = 0;

    // contention from a clean streak
    do_reset(0);
    for (int i = 0; i < 10; i++) dq.push_back(rand_d(0));
    for (int i = 0; i < 3; i++) iq.push_back(64'h8000_1000 + 64'(i * 4));
    wait_done("contention", 400);
    check("contention_grants", glog.size() >= 10, 1);
    for (int i = 0; i < 10 && i < glog.size(); i++)
      check($sformatf("contention_grant%0d", i), glog[i], !(i == 4 || i == 9));

    // data requester drops valid while its access is in flight
    do_reset(0);
    dq.push_back(rand_d(1));
    iq.push_back(64'h8000_2008);
    wait_done("dropped", 80);
    check("drop_first_d", glog.size() >= 2 && glog[0] == 1, 1);
    check("drop_next_i", glog.size() >= 2 && glog[1] == 0, 1);
    check("drop_dok_count", n_dok, 1);
    check("drop_iok_count", n_iok, 1);

    // reset while waiting for the response
    fix_resp = 30;
    iq.push_back(64'h8000_0200);
    n = 0;
    while (!outstanding && n < 40) begin @(posedge clk); #1; n++; end
    if (!outstanding) fail("reach_wait", "fetch never accepted downstream");
    repeat (2) @(posedge clk);
    do_reset(1);
    fix_resp = 0;
    iq.push_back(64'h8000_020C);
    wait_done("post_reset_fetch", 50);
    check("post_reset_count", n_iok, 1);
    check("post_reset_data", {32'h0, last_idata}, fetch_exp(64'h8000_020C));

    // randomized traffic with random stalls and spurious responses
    do_reset(0);
    rand_mode = 1; spurious = 1;
    for (int i = 0; i < 80; i++) begin
      iq.push_back(64'h8000_0000 + 64'($urandom_range(0, 1023) * 4));
      dq.push_back(rand_d($urandom_range(0, 7) == 0));
    end
    wait_done("random", 6000);
    check("random_iok_count", n_iok, 80);
    check("random_dok_count", n_dok, 80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
